pipe_skid_stage: RTL and testbench

//  Generic, parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_skid_stage_if.sv | 24 ++
 rtl/pipe_skid_stage.sv | 84 ++++++++
 tb/tb_pipe_skid_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready channel bundle for pipe_skid_stage: upstream accept side and downstream emit side.
interface pipe_skid_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  // Stage view: consumes the upstream beat, produces the downstream beat.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  // Surrounding-logic view: drives upstream beats and downstream back-pressure.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// registered in_ready (no combinational path from out_ready) and synchronous flush.
module pipe_skid_stage #(
  parameter int unsigned           WIDTH      = 32,
  parameter logic [WIDTH-1:0]      BUBBLE_VAL = '0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Flush,
  pipe_skid_stage_if.slave bus
);

  // Encoding equals the number of held beats, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, emit;

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign emit   = bus.out_valid & bus.out_ready;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
    skid_q <= skid_d;
  end

  // main_q is reloaded with BUBBLE_VAL whenever the stage drains, so out_data needs no output mux.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = bus.in_data;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (accept && emit) begin
          main_d  = bus.in_data;
        end else if (emit) begin
          state_d = EMPTY;
          main_d  = BUBBLE_VAL;
        end
      end
      FULL: begin
        if (emit) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE_VAL;
      end
    endcase
    if (Flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VAL;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table on a 32-bit stage, then randomised
// handshakes on 32/7/64-bit stages checked against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam logic [31:0] BUB_A = 32'hDEAD_BEEF;
  localparam logic [6:0]  BUB_B = 7'h55;
  localparam logic [63:0] BUB_C = 64'hA5A5_0000_FFFF_1234;

  logic        CLK = 1'b0;
  logic        rst, flush, iv, ordy;
  logic [63:0] din;

  always #5 CLK = ~CLK;

  pipe_skid_stage_if #(.WIDTH(32)) ifa ();
  pipe_skid_stage_if #(.WIDTH(7))  ifb ();
  pipe_skid_stage_if #(.WIDTH(64)) ifc ();

  assign ifa.in_valid  = iv;
  assign ifa.in_data   = din[31:0];
  assign ifa.out_ready = ordy;
  assign ifb.in_valid  = iv;
  assign ifb.in_data   = din[6:0];
  assign ifb.out_ready = ordy;
  assign ifc.in_valid  = iv;
  assign ifc.in_data   = din;
  assign ifc.out_ready = ordy;

  pipe_skid_stage #(.WIDTH(32), .BUBBLE_VAL(BUB_A)) dut_a (
    .CLK(CLK), .Reset(rst), .Flush(flush), .bus(ifa.slave));
  pipe_skid_stage #(.WIDTH(7), .BUBBLE_VAL(BUB_B)) dut_b (
    .CLK(CLK), .Reset(rst), .Flush(flush), .bus(ifb.slave));
  pipe_skid_stage #(.WIDTH(64), .BUBBLE_VAL(BUB_C)) dut_c (
    .CLK(CLK), .Reset(rst), .Flush(flush), .bus(ifc.slave));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [31:0] din;
    logic        ov, ir;
    logic [31:0] dout;
    logic [1:0]  occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic f, input logic v, input logic o,
                              input logic [31:0] d, input logic eov, input logic eir,
                              input logic [31:0] edo, input logic [1:0] eocc);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = v; t.ordy = o; t.din = d;
    t.ov = eov; t.ir = eir; t.dout = edo; t.occ = eocc;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] q[$];
    logic        m_accept, m_emit;

    rst = 1'b1; flush = 1'b0; iv = 1'b0; ordy = 1'b0; din = '0;

    //              rst flush iv ordy din      ov ir dout    occ
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0, 1, BUB_A, 2'd0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0, 1, BUB_A, 2'd0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 0, 1, 1, 32'(k), 1, 1, 32'(k), 2'd1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  0, 1, BUB_A, 2'd0));
    // stall fills skid; a refused beat while FULL is not taken
    tbl.push_back(mk(0, 0, 1, 0, 32'hA,  1, 1, 32'hA, 2'd1));
    tbl.push_back(mk(0, 0, 1, 0, 32'hB,  1, 0, 32'hA, 2'd2));
    tbl.push_back(mk(0, 0, 1, 0, 32'hEE, 1, 0, 32'hA, 2'd2));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  1, 1, 32'hB, 2'd1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  0, 1, BUB_A, 2'd0));
    // flush from FULL with a same-cycle beat
    tbl.push_back(mk(0, 0, 1, 0, 32'hA,  1, 1, 32'hA, 2'd1));
    tbl.push_back(mk(0, 0, 1, 0, 32'hB,  1, 0, 32'hA, 2'd2));
    tbl.push_back(mk(0, 1, 1, 0, 32'hC,  0, 1, BUB_A, 2'd0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  0, 1, BUB_A, 2'd0));
    // flush from ONE with simultaneous accept and emit
    tbl.push_back(mk(0, 0, 1, 1, 32'h11, 1, 1, 32'h11, 2'd1));
    tbl.push_back(mk(0, 1, 1, 1, 32'h22, 0, 1, BUB_A, 2'd0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  0, 1, BUB_A, 2'd0));
    // reset over flush while FULL, then first beat after release
    tbl.push_back(mk(0, 0, 1, 0, 32'hA,  1, 1, 32'hA, 2'd1));
    tbl.push_back(mk(0, 0, 1, 0, 32'hB,  1, 0, 32'hA, 2'd2));
    tbl.push_back(mk(1, 1, 1, 0, 32'hC,  0, 1, BUB_A, 2'd0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h5,  1, 1, 32'h5, 2'd1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  0, 1, BUB_A, 2'd0));
    // FULL drain with upstream still offering beats
    tbl.push_back(mk(0, 0, 1, 0, 32'h31, 1, 1, 32'h31, 2'd1));
    tbl.push_back(mk(0, 0, 1, 0, 32'h32, 1, 0, 32'h31, 2'd2));
    tbl.push_back(mk(0, 0, 1, 1, 32'h33, 1, 1, 32'h32, 2'd1));
    tbl.push_back(mk(0, 0, 1, 1, 32'h34, 1, 1, 32'h34, 2'd1));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,  0, 1, BUB_A, 2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      rst = tbl[i].rst; flush = tbl[i].flush; iv = tbl[i].iv; ordy = tbl[i].ordy;
      din = {32'h0, tbl[i].din};
      @(posedge CLK);
      #1;
      check($sformatf("v%0d out_valid", i), 64'(ifa.out_valid), 64'(tbl[i].ov));
      check($sformatf("v%0d in_ready", i),  64'(ifa.in_ready),  64'(tbl[i].ir));
      check($sformatf("v%0d out_data", i),  64'(ifa.out_data),  64'(tbl[i].dout));
      check($sformatf("v%0d occupancy", i), 64'(ifa.occupancy), 64'(tbl[i].occ));
    end

    // in_ready must not follow out_ready within a cycle, in ONE and in FULL
    @(negedge CLK); iv = 1'b1; din = 64'h41; ordy = 1'b0;
    @(posedge CLK); #1; iv = 1'b0;
    ordy = 1'b1; #1;
    check("comb ONE in_ready", 64'(ifa.in_ready), 64'd1);
    ordy = 1'b0;
    @(negedge CLK); iv = 1'b1; din = 64'h42;
    @(posedge CLK); #1; iv = 1'b0;
    ordy = 1'b1; #1;
    check("comb FULL in_ready", 64'(ifa.in_ready), 64'd0);
    ordy = 1'b0;
    // long stall: head beat and valid stay put
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); iv = 1'b1; din = 64'h99;
      check($sformatf("stall%0d out_data", c), 64'(ifa.out_data), 64'h41);
      check($sformatf("stall%0d out_valid", c), 64'(ifa.out_valid), 64'd1);
      check($sformatf("stall%0d occupancy", c), 64'(ifa.occupancy), 64'd2);
    end
    @(negedge CLK); iv = 1'b0; ordy = 1'b1;
    @(posedge CLK); #1;
    check("drain first", 64'(ifa.out_data), 64'h42);
    @(posedge CLK); #1;
    check("drain bubble", 64'(ifa.out_data), 64'(BUB_A));
    check("drain occupancy", 64'(ifa.occupancy), 64'd0);

    // randomised run on all three widths against a queue model
    @(negedge CLK); rst = 1'b1; iv = 1'b0; ordy = 1'b0; flush = 1'b0;
    @(negedge CLK);
    q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      rst   = 1'b0;
      flush = ($urandom_range(0, 63) == 0);
      iv    = 1'($urandom_range(0, 1));
      ordy  = ($urandom_range(0, 3) != 0) ^ (cyc % 200 < 40);
      din   = {$urandom, $urandom};
      #1;
      if (q.size() > 0) begin
        check("rnd A data", 64'(ifa.out_data), 64'(q[0][31:0]));
        check("rnd B data", 64'(ifb.out_data), 64'(q[0][6:0]));
        check("rnd C data", ifc.out_data, q[0]);
      end else begin
        check("rnd A bubble", 64'(ifa.out_data), 64'(BUB_A));
        check("rnd B bubble", 64'(ifb.out_data), 64'(BUB_B));
        check("rnd C bubble", ifc.out_data, BUB_C);
      end
      check("rnd A out_valid", 64'(ifa.out_valid), 64'(q.size() > 0));
      check("rnd B out_valid", 64'(ifb.out_valid), 64'(q.size() > 0));
      check("rnd C out_valid", 64'(ifc.out_valid), 64'(q.size() > 0));
      check("rnd A occupancy", 64'(ifa.occupancy), 64'(q.size()));
      check("rnd B occupancy", 64'(ifb.occupancy), 64'(q.size()));
      check("rnd C occupancy", 64'(ifc.occupancy), 64'(q.size()));
      check("rnd B in_ready", 64'(ifb.in_ready), 64'(q.size() < 2));
      check("rnd C in_ready", 64'(ifc.in_ready), 64'(q.size() < 2));
      ordy = ~ordy; #1;
      check("rnd A in_ready comb", 64'(ifa.in_ready), 64'(q.size() < 2));
      ordy = ~ordy; #1;
      m_accept = iv && (q.size() < 2);
      m_emit   = ordy && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (m_emit) void'(q.pop_front());
        if (m_accept) q.push_back(din);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
